ifu_fetch: RTL and testbench
============================

// Module: ifu_fetch
// PURPOSE
//  Instruction fetch unit; the producer end of the fetch->decode link. Holds the PC, issues one
//  32-bit instruction-memory read at a time, and presents {vld, inst, pc} to decode. Accepts
//  redirects (branch, jump, trap, mret) from execute and discards stale fetches.
// PARAMETERS
//  RESET_PC  64'h8000_0000  PC loaded on reset
//  XLEN      64             PC / address width
// PORTS
//  clk            in   1     clock
//  rst_n          in   1     synchronous, active-low reset
//  imem_req_vld   out  1     fetch request valid
//  imem_req_rdy   in   1     memory accepts request
//  imem_addr      out  XLEN  fetch address (bits [1:0] always 0)
//  imem_rsp_vld   in   1     response valid (exactly one per accepted request)
//  imem_rsp_data  in   32    fetched instruction word
//  redirect_vld   in   1     execute requests PC change (1-cycle pulse)
//  redirect_pc    in   XLEN  new PC; bits [1:0] are ignored (forced to 0)
//  idu_rdy        in   1     decode can take an instruction this cycle
//  ifu_vld        out  1     instruction valid to decode
//  ifu_inst       out  64    {32'b0, instruction word}
//  ifu_pc         out  XLEN  PC of ifu_inst
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): pc=RESET_PC, state=S_IDLE, imem_req_vld=0, ifu_vld=0,
//    ifu_inst=0, ifu_pc=RESET_PC, drop=0.
//  - FSM (one outstanding request max):
//    S_IDLE : 1 cycle after reset release -> S_REQ.
//    S_REQ  : imem_req_vld=1, imem_addr=pc. Stable until imem_req_rdy. On handshake -> S_WAIT.
//    S_WAIT : on imem_rsp_vld: ifu_inst<={32'b0,data}, ifu_pc<=pc, ifu_vld<=1, -> S_HOLD.
//    S_HOLD : ifu_vld=1. When idu_rdy: ifu_vld<=0, pc<=next_pc, -> S_REQ.
//             (Issue is not overlapped: best case 1 instruction every 3 cycles with 0-wait memory.)
//    S_DRAIN: swallow the one stale response (no output), then -> S_REQ.
//  - next_pc = pc+4 (64-bit wrap, no overflow detection).
//  - Redirect has priority over every other event in the same cycle; pc<=redirect_pc & ~3:
//    S_IDLE/S_REQ without handshake -> S_REQ (req_vld may drop; addr changes next cycle).
//    S_REQ with handshake same cycle -> S_DRAIN (accepted request is stale).
//    S_WAIT without rsp -> S_DRAIN; S_WAIT with rsp same cycle -> rsp discarded, -> S_REQ.
//    S_HOLD -> ifu_vld<=0 even if idu_rdy=1 (held inst is dropped), -> S_REQ.
//    S_DRAIN -> stay S_DRAIN (still one stale rsp pending); if rsp arrives same cycle -> S_REQ.
//  - ifu_vld is registered; ifu_inst/ifu_pc are stable while ifu_vld=1 and !idu_rdy.
//  - Reset mid-transaction: state forced to reset values; any in-flight memory response after
//    reset is the memory's responsibility (memory is reset with the same rst_n).
//  - imem_rsp_vld outside S_WAIT/S_DRAIN is a protocol error: ignored (assertion in sim).
// CONFIGURATION
//  IFU_PREDECODE_JAL_EN defined: in S_WAIT, if data[6:0]==RV_JAL, next_pc=pc+J-imm (sext,
//   64-bit wrap) instead of pc+4; execute must not redirect for JAL.
//  Undefined: next_pc is always pc+4; JAL is resolved by execute via redirect.
// STRUCTURE
//  - Shared package: RV_* opcode constants (RV_JAL etc.), ifu_state_e {S_IDLE,S_REQ,S_WAIT,
//    S_HOLD,S_DRAIN}, RESET_PC default constant.
//  - Sub-module ifu_jal_predecode (combinational: inst, pc -> is_jal, target); instantiated only
//    under IFU_PREDECODE_JAL_EN.
// TESTING
//  1 Reset, rdy=1, 0-wait mem returning 0x00000013: imem_addr=0x80000000, then 0x80000004;
//    ifu_vld pulses with ifu_pc 0x80000000, 0x80000004, ifu_inst=0x0000000000000013.
//  2 idu_rdy=0 for 5 cycles in S_HOLD: ifu_vld,ifu_inst,ifu_pc stable; no new imem request.
//  3 imem_req_rdy held 0 for 4 cycles: imem_req_vld=1, addr stable 0x80000000 throughout.
//  4 redirect to 0x80001002 while in S_WAIT: stale rsp not presented; next addr=0x80001000,
//    next ifu_pc=0x80001000.
//  5 redirect same cycle as rsp in S_WAIT, and same cycle as idu_rdy in S_HOLD: no ifu_vld for
//    old PC; next fetch at redirect target.
//  6 (IFU_PREDECODE_JAL_EN) inst 0x0100006F (jal x0,16) at 0x80000000: next addr 0x80000010;
//    without macro: 0x80000004.

Source files
------------

// File: rtl/ifu_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Optional feature: IFU_PREDECODE_JAL_EN (JAL target resolved at fetch).
package ifu_fetch_pkg;

    localparam logic [63:0] RESET_PC_DEF = 64'h8000_0000;

    localparam logic [6:0] RV_OP_IMM = 7'b0010011;
    localparam logic [6:0] RV_BRANCH = 7'b1100011;
    localparam logic [6:0] RV_JALR   = 7'b1100111;
    localparam logic [6:0] RV_JAL    = 7'b1101111;
    localparam logic [6:0] RV_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DRAIN
    } ifu_state_e;

    // J-type immediate, 21 bits with the implicit zero LSB
    function automatic logic [20:0] j_imm(input logic [31:0] inst);
        return {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/ifu_fetch_if.sv
// Fetch unit links: instruction memory, execute redirect and decode.
// master = fetch unit side, slave = environment side.
interface ifu_fetch_if #(
    parameter int XLEN = 64
);
    logic            imem_req_vld;
    logic            imem_req_rdy;
    logic [XLEN-1:0] imem_addr;
    logic            imem_rsp_vld;
    logic [31:0]     imem_rsp_data;
    logic            redirect_vld;
    logic [XLEN-1:0] redirect_pc;
    logic            idu_rdy;
    logic            ifu_vld;
    logic [63:0]     ifu_inst;
    logic [XLEN-1:0] ifu_pc;

    modport master (
        output imem_req_vld, imem_addr, ifu_vld, ifu_inst, ifu_pc,
        input  imem_req_rdy, imem_rsp_vld, imem_rsp_data,
        input  redirect_vld, redirect_pc, idu_rdy
    );

    modport slave (
        input  imem_req_vld, imem_addr, ifu_vld, ifu_inst, ifu_pc,
        output imem_req_rdy, imem_rsp_vld, imem_rsp_data,
        output redirect_vld, redirect_pc, idu_rdy
    );
endinterface

// File: rtl/ifu_jal_predecode.sv
// Combinational JAL detect and target compute for fetch-side prediction.
// Instantiated by ifu_fetch only when IFU_PREDECODE_JAL_EN is defined.
module ifu_jal_predecode
    import ifu_fetch_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [31:0]     i_inst,
    input  logic [XLEN-1:0] i_pc,
    output logic            o_is_jal,
    output logic [XLEN-1:0] o_target
);
    logic [20:0] w_imm;
    logic        w_unused_rd;

    assign w_imm       = j_imm(i_inst);
    assign w_unused_rd = ^i_inst[11:7];
    assign o_is_jal    = (i_inst[6:0] == RV_JAL);
    assign o_target    = i_pc + {{(XLEN-21){w_imm[20]}}, w_imm};
endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: one outstanding imem read, redirect with stale drop.
// Define IFU_PREDECODE_JAL_EN to follow JAL targets at fetch.
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC = RESET_PC_DEF,
    parameter int          XLEN     = 64
) (
    input logic         clk,
    input logic         rst_n,
    ifu_fetch_if.master bus
);
    localparam logic [XLEN-1:0] W_RST = RESET_PC[XLEN-1:0];

    ifu_state_e      r_state, w_state_nxt;
    logic [XLEN-1:0] r_pc, r_npc, w_npc;
    logic            r_vld;
    logic [63:0]     r_inst;
    logic [XLEN-1:0] r_ipc;
    logic            w_hs, w_rsp, w_redir;
    logic            w_capture, w_advance;

    assign w_hs  = (r_state == S_REQ) && bus.imem_req_rdy;
    assign w_rsp = bus.imem_rsp_vld;
    assign w_redir = bus.redirect_vld;

`ifdef IFU_PREDECODE_JAL_EN
    logic            w_is_jal;
    logic [XLEN-1:0] w_jal_tgt;

    ifu_jal_predecode #(.XLEN(XLEN)) u_pdec (
        .i_inst   (bus.imem_rsp_data),
        .i_pc     (r_pc),
        .o_is_jal (w_is_jal),
        .o_target (w_jal_tgt)
    );

    assign w_npc = w_is_jal ? w_jal_tgt : r_pc + XLEN'(4);
`else
    assign w_npc = r_pc + XLEN'(4);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_advance   = 1'b0;
        if (w_redir) begin
            // a request already accepted or a response still owed must be swallowed
            case (r_state)
                S_REQ:   w_state_nxt = w_hs  ? S_DRAIN : S_REQ;
                S_WAIT:  w_state_nxt = w_rsp ? S_REQ : S_DRAIN;
                S_DRAIN: w_state_nxt = w_rsp ? S_REQ : S_DRAIN;
                default: w_state_nxt = S_REQ;
            endcase
        end else begin
            case (r_state)
                S_IDLE:  w_state_nxt = S_REQ;
                S_REQ:   if (w_hs) w_state_nxt = S_WAIT;
                S_WAIT: begin
                    if (w_rsp) begin
                        w_state_nxt = S_HOLD;
                        w_capture   = 1'b1;
                    end
                end
                S_HOLD: begin
                    if (bus.idu_rdy) begin
                        w_state_nxt = S_REQ;
                        w_advance   = 1'b1;
                    end
                end
                S_DRAIN: if (w_rsp) w_state_nxt = S_REQ;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc   <= W_RST;
            r_npc  <= W_RST + XLEN'(4);
            r_vld  <= 1'b0;
            r_inst <= '0;
            r_ipc  <= W_RST;
        end else if (w_redir) begin
            r_pc  <= bus.redirect_pc & ~XLEN'(3);
            r_vld <= 1'b0;
        end else if (w_capture) begin
            r_vld  <= 1'b1;
            r_inst <= {32'b0, bus.imem_rsp_data};
            r_ipc  <= r_pc;
            r_npc  <= w_npc;
        end else if (w_advance) begin
            r_vld <= 1'b0;
            r_pc  <= r_npc;
        end
    end

    assign bus.imem_req_vld = (r_state == S_REQ);
    assign bus.imem_addr    = r_pc;
    assign bus.ifu_vld      = r_vld;
    assign bus.ifu_inst     = r_inst;
    assign bus.ifu_pc       = r_ipc;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst_n && w_rsp)
            assert (r_state == S_WAIT || r_state == S_DRAIN);
    end
`endif
endmodule

// File: tb/tb_ifu_fetch.sv
// Randomized scoreboard bench for ifu_fetch with a program-order fetch model.
// Define IFU_PREDECODE_JAL_EN to check the fetch-side JAL build.
module tb_ifu_fetch;
    import ifu_fetch_pkg::*;

    localparam logic [63:0] RST = 64'h8000_0000;
    localparam logic [63:0] JAL_AT = 64'h8000_0100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    ifu_fetch_if #(.XLEN(64)) bus ();

    ifu_fetch #(.RESET_PC(RST), .XLEN(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int n_acc = 0;

    // head = PC of the next instruction decode must receive
    logic [63:0] exp_q[$];

    bit          m_pend;
    logic [63:0] m_addr;
    int          m_cnt;
    int          p_rdy, p_idu, max_dly;

    function automatic logic [31:0] memfn(input logic [63:0] a);
        if (a == JAL_AT) return 32'h0100006F;
        return {a[26:2], 7'h13};
    endfunction

    function automatic logic [63:0] model_next(input logic [63:0] pc);
`ifdef IFU_PREDECODE_JAL_EN
        if (memfn(pc) == 32'h0100006F) return pc + 64'd16;
`endif
        return pc + 64'd4;
    endfunction

    function automatic void chk(input string nm, input logic [63:0] act,
                                input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endfunction

    task automatic cyc(input bit redir, input logic [63:0] tgt);
        @(negedge clk);
        bus.imem_req_rdy = ($urandom_range(99) < p_rdy);
        bus.idu_rdy      = ($urandom_range(99) < p_idu);
        bus.redirect_vld = redir;
        bus.redirect_pc  = tgt;
        if (redir) begin
            exp_q.delete();
            exp_q.push_back(tgt & ~64'd3);
        end
        if (m_pend && m_cnt == 0) begin
            bus.imem_rsp_vld  = 1'b1;
            bus.imem_rsp_data = memfn(m_addr);
        end else begin
            bus.imem_rsp_vld  = 1'b0;
            bus.imem_rsp_data = $urandom;
        end
        #1;
        if (bus.imem_rsp_vld) m_pend = 1'b0;
        else if (m_pend) m_cnt--;
        if (bus.imem_req_vld && bus.imem_req_rdy) begin
            m_pend = 1'b1;
            m_addr = bus.imem_addr;
            m_cnt  = $urandom_range(max_dly);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.imem_req_rdy = 1'b0;
        bus.imem_rsp_vld = 1'b0;
        bus.redirect_vld = 1'b0;
        bus.idu_rdy      = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_req_vld", 64'(bus.imem_req_vld), 64'd0);
        chk("rst_ifu_vld", 64'(bus.ifu_vld), 64'd0);
        chk("rst_ifu_inst", bus.ifu_inst, 64'd0);
        chk("rst_ifu_pc", bus.ifu_pc, RST);
        chk("rst_addr", bus.imem_addr, RST);
        m_pend = 1'b0;
        exp_q.delete();
        exp_q.push_back(RST);
        rst_n = 1'b1;
    endtask

    function automatic logic [63:0] pick_tgt();
        case ($urandom_range(3))
            0:       return RST + 64'($urandom_range(255));
            1:       return JAL_AT;
            2:       return {$urandom, $urandom};
            default: return 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(15));
        endcase
    endfunction

    bit          pv_hold, pv_req;
    logic [63:0] pv_pc, pv_inst, pv_addr;
    int          idle;

    always @(negedge clk) begin
        logic [63:0] e;
        logic        red;
        #2;
        red = bus.redirect_vld;
        if (!rst_n) begin
            pv_hold = 1'b0;
            pv_req  = 1'b0;
            idle    = 0;
        end else begin
            if (pv_hold) begin
                chk("hold_vld", 64'(bus.ifu_vld), 64'd1);
                chk("hold_pc", bus.ifu_pc, pv_pc);
                chk("hold_inst", bus.ifu_inst, pv_inst);
            end
            if (pv_req) begin
                chk("req_vld_stable", 64'(bus.imem_req_vld), 64'd1);
                chk("req_addr_stable", bus.imem_addr, pv_addr);
            end
            if (bus.ifu_vld)
                chk("no_req_in_hold", 64'(bus.imem_req_vld), 64'd0);
            if (bus.imem_req_vld)
                chk("addr_align", 64'(bus.imem_addr[1:0]), 64'd0);
            if (bus.imem_req_vld && bus.imem_req_rdy && !red) begin
                if (exp_q.size() == 0) chk("fetch_exp_empty", 64'd1, 64'd0);
                else chk("fetch_addr", bus.imem_addr, exp_q[0]);
            end
            if (bus.ifu_vld && bus.idu_rdy && !red) begin
                if (exp_q.size() == 0) begin
                    chk("deliver_exp_empty", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("ifu_pc", bus.ifu_pc, e);
                    chk("ifu_inst", bus.ifu_inst, {32'b0, memfn(e)});
                    exp_q.push_back(model_next(e));
                end
                n_acc++;
                idle = 0;
            end else if (red) begin
                idle = 0;
            end else begin
                idle++;
            end
            if (idle > 100) begin
                chk("progress_timeout", 64'(idle), 64'd0);
                idle = 0;
            end
            pv_hold = bus.ifu_vld && !bus.idu_rdy && !red;
            pv_pc   = bus.ifu_pc;
            pv_inst = bus.ifu_inst;
            pv_req  = bus.imem_req_vld && !bus.imem_req_rdy && !red;
            pv_addr = bus.imem_addr;
        end
    end

    initial begin
        logic [63:0] dir_t[4];
        bus.imem_req_rdy  = 1'b0;
        bus.imem_rsp_vld  = 1'b0;
        bus.imem_rsp_data = '0;
        bus.redirect_vld  = 1'b0;
        bus.redirect_pc   = '0;
        bus.idu_rdy       = 1'b0;
        m_pend = 1'b0;
        m_cnt  = 0;
        m_addr = '0;
        p_rdy = 100;
        p_idu = 100;
        max_dly = 0;

        do_reset();
        repeat (30) cyc(1'b0, '0);

        p_idu = 15;
        repeat (60) cyc(1'b0, '0);

        p_idu = 100;
        p_rdy = 20;
        repeat (60) cyc(1'b0, '0);

        p_rdy = 100;
        max_dly = 2;
        dir_t[0] = 64'h8000_1002;
        dir_t[1] = JAL_AT;
        dir_t[2] = 64'hFFFF_FFFF_FFFF_FFFE;
        dir_t[3] = 64'h8000_0003;
        for (int k = 0; k < 4; k++) begin
            cyc(1'b1, dir_t[k]);
            repeat (14) cyc(1'b0, '0);
        end

        p_rdy = 60;
        p_idu = 60;
        max_dly = 3;
        for (int i = 0; i < 4000; i++) begin
            if (i == 2000) do_reset();
            cyc($urandom_range(9) == 0, pick_tgt());
        end
        @(negedge clk);
        #3;
        chk("enough_deliveries", 64'(n_acc >= 100), 64'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
